// File: rtl/key_sw_conditioner_pkg.sv
// Shared I/O constants for the UI block: conditioner defaults and device addresses.
package key_sw_conditioner_pkg;

    localparam int unsigned NKEYS_DEFAULT           = 4;
    localparam int unsigned NSW_DEFAULT             = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int unsigned CNT_BITS_DEFAULT        = 20;

    localparam logic [31:0] UI_BASE_ADDR = 32'hFF20_0000;

    typedef enum logic [1:0] {
        UiKeyLevel   = 2'd0,
        UiSwLevel    = 2'd1,
        UiKeyPressed = 2'd2,
        UiKeyClear   = 2'd3
    } uiReg_e;

    // Registers are word-spaced from the UI base.
    function automatic logic [31:0] uiRegAddr(input uiReg_e reg_sel);
        return UI_BASE_ADDR + {28'd0, reg_sel, 2'b00};
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, optional inversion, and a hold-time debouncer.
module debounce_bit
    import key_sw_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_BITS        = CNT_BITS_DEFAULT,
    parameter logic        SYNC_RESET      = 1'b0,
    parameter logic        INVERT          = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [1:0]          syncQ;
    logic                syncVal;
    logic                stableQ, stableD;
    logic [CNT_BITS-1:0] cntQ, cntD;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncQ   <= {2{SYNC_RESET}};
            cntQ    <= '0;
            stableQ <= 1'b0;
        end else begin
            syncQ   <= {syncQ[0], raw};
            cntQ    <= cntD;
            stableQ <= stableD;
        end
    end

    assign syncVal = syncQ[1] ^ INVERT;

    // Any cycle where sync agrees with stable clears the count, rejecting glitches.
    always_comb begin
        cntD    = '0;
        stableD = stableQ;
        if (syncVal != stableQ) begin
            if (cntQ == CNT_LAST) begin
                stableD = syncVal;
            end else begin
                cntD = cntQ + CNT_BITS'(1);
            end
        end
    end

    assign level = stableQ;

endmodule

// File: rtl/key_sw_conditioner.sv
// Debounces push-buttons and slide switches and captures sticky button-press flags.
module key_sw_conditioner
    import key_sw_conditioner_pkg::*;
#(
    parameter int unsigned NKEYS           = NKEYS_DEFAULT,
    parameter int unsigned NSW             = NSW_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_BITS        = CNT_BITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NKEYS-1:0] KEY,
    input  logic [NSW-1:0]   SW,
    input  logic             keyClr,
    input  logic [NKEYS-1:0] clrMask,
    output logic [NKEYS-1:0] keyLevel,
    output logic [NSW-1:0]   swLevel,
    output logic [NKEYS-1:0] keyPressed,
    output logic             keyEvent
);

    // Buttons idle high, so their synchronizers reset to the released level.
    for (genvar i = 0; i < NKEYS; i++) begin : gKey
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_BITS       (CNT_BITS),
            .SYNC_RESET     (1'b1),
            .INVERT         (1'b1)
        ) uKeyDebounce (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (KEY[i]),
            .level  (keyLevel[i])
        );
    end

    for (genvar i = 0; i < NSW; i++) begin : gSw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_BITS       (CNT_BITS),
            .SYNC_RESET     (1'b0),
            .INVERT         (1'b0)
        ) uSwDebounce (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (SW[i]),
            .level  (swLevel[i])
        );
    end

    logic [NKEYS-1:0] keyLevelPrevQ;
    logic [NKEYS-1:0] keyPressedQ, keyPressedD;
    logic             keyEventQ, keyEventD;
    logic [NKEYS-1:0] keyRise;
    logic [NKEYS-1:0] clrBits;

    always_comb begin
        keyRise     = keyLevel & ~keyLevelPrevQ;
        clrBits     = keyClr ? clrMask : '0;
        // Set wins over a coincident clear.
        keyPressedD = (keyPressedQ & ~clrBits) | keyRise;
        keyEventD   = |(keyRise & ~keyPressedQ);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keyLevelPrevQ <= '0;
            keyPressedQ   <= '0;
            keyEventQ     <= 1'b0;
        end else begin
            keyLevelPrevQ <= keyLevel;
            keyPressedQ   <= keyPressedD;
            keyEventQ     <= keyEventD;
        end
    end

    assign keyPressed = keyPressedQ;
    assign keyEvent   = keyEventQ;

endmodule

// File: doc/key_sw_conditioner.md
KEY_SW_CONDITIONER -- requirements
Module: key_sw_conditioner

Interface
REQ-001 SHALL have parameter NKEYS, default 4: number of push-button inputs.
REQ-002 SHALL have parameter NSW, default 10: number of slide-switch inputs.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000: cycles an input must hold a new value before it is accepted (10 ms at 50 MHz); legal range 2 to 2^CNT_BITS.
REQ-004 SHALL have parameter CNT_BITS, default 20: debounce counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port KEY, input, NKEYS bits: raw asynchronous buttons, active-low (0 = pressed).
REQ-008 SHALL have port SW, input, NSW bits: raw asynchronous switches, active-high.
REQ-009 SHALL have port keyClr, input, 1 bit: processor write strobe that clears sticky press bits.
REQ-010 SHALL have port clrMask, input, NKEYS bits: bits to clear when keyClr=1.
REQ-011 SHALL have port keyLevel, output, NKEYS bits: debounced button state, active-high (1 = pressed).
REQ-012 SHALL have port swLevel, output, NSW bits: debounced switch state.
REQ-013 SHALL have port keyPressed, output, NKEYS bits: sticky press-captured flags.
REQ-014 SHALL have port keyEvent, output, 1 bit: one-cycle pulse when any keyPressed bit newly sets.

Function
REQ-015 SHALL pass every KEY and SW bit through a two-flop synchronizer before any other logic uses it; KEY is inverted after synchronization.
REQ-016 SHALL hold, per input bit, a stable value and a CNT_BITS counter; when sync==stable the counter SHALL be 0.
REQ-017 SHALL increment the counter each cycle that sync!=stable; when the count reaches DEBOUNCE_CYCLES-1, stable SHALL take sync and the counter SHALL return to 0 on that same edge.
REQ-018 SHALL reset the counter to 0 with stable unchanged on any cycle where sync returns to stable before acceptance (glitch rejection).
REQ-019 SHALL give a latency of exactly 2+DEBOUNCE_CYCLES cycles from a clean raw transition to the change on keyLevel/swLevel.
REQ-020 SHALL set keyPressed[i] on the cycle after keyLevel[i] rises 0->1; a falling edge SHALL NOT affect it.
REQ-021 SHALL clear keyPressed[i] on the clock after keyClr=1 with clrMask[i]=1; bits with clrMask=0 SHALL be retained.
REQ-022 SHALL give set priority when set and clear of the same bit coincide: the bit ends at 1 and keyEvent pulses.
REQ-023 SHALL assert keyEvent for exactly one cycle, aligned with the keyPressed update, when at least one bit goes 0->1; a bit already at 1 SHALL NOT generate keyEvent.
REQ-024 SHALL provide independent counters per bit, so simultaneous transitions on several inputs are each accepted on their own schedule.
REQ-025 SHALL have registered outputs with no combinational path from any input to any output.

Reset
REQ-026 SHALL drive, while reset_n=0: KEY sync flops to 1 (released); SW sync flops to 0; all counters to 0; keyLevel, swLevel, keyPressed and keyEvent to 0.
REQ-027 SHALL abandon any in-progress debounce count when reset is asserted mid-count; after release, a held button SHALL need the full 2+DEBOUNCE_CYCLES to appear and SHALL then set keyPressed.
REQ-028 SHALL produce no keyEvent in the first cycle after reset release.

Structure
REQ-029 SHALL place the defaults for NKEYS, NSW, DEBOUNCE_CYCLES and CNT_BITS in the shared I/O constants header, alongside the UI device address constants.
REQ-030 SHALL implement one sub-module, debounce_bit (synchronizer, counter, stable flop, parameterised reset value), instantiated NKEYS+NSW times.

Verification (DEBOUNCE_CYCLES=8, CNT_BITS=4)
REQ-031 SHALL cover: KEY[0] 1->0 held -> keyLevel[0]=1 exactly 10 cycles later; keyPressed[0]=1 and a single keyEvent pulse on the next cycle.
REQ-032 SHALL cover: KEY[1] low for 5 cycles then high -> keyLevel, keyPressed and keyEvent all stay 0.
REQ-033 SHALL cover: keyPressed=4'b1011 and keyClr=1 with clrMask=4'b0011 -> keyPressed=4'b1000 next cycle and no keyEvent.
REQ-034 SHALL cover: keyClr with clrMask[2]=1 in the same cycle keyPressed[2] would set -> keyPressed[2]=1 and keyEvent=1.
REQ-035 SHALL cover: SW=10'h2A5 applied at once -> swLevel=10'h2A5 after 10 cycles; SW[0] toggling every 3 cycles -> swLevel[0] unchanged.
REQ-036 SHALL cover: reset_n pulsed low at cycle 5 of a KEY[3] press -> all outputs 0 immediately; keyLevel[3]=1 10 cycles after release.
